uart_pkt_rx_ctrl: RTL

UART_PKT_RX_CTRL -- requirements
Module: uart_pkt_rx_ctrl

---
 rtl/uart_pkt_rx_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_pkt_rx_ctrl.sv
// rtl/uart_pkt_rx_ctrl.sv - UART byte-stream packet deframer with checksum, inter-byte timeout and buffered output
module uart_pkt_rx_ctrl #(
    parameter int unsigned CLOCK_FREQ    = 50_000_000,
    parameter int unsigned BAUD_RATE     = 9600,
    parameter int unsigned MAX_LEN       = 16,
    parameter logic [7:0]  SOF           = 8'hA5,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic [7:0] o_pkt_data,
    output logic       o_pkt_valid,
    input  logic       i_pkt_ready,
    output logic       o_pkt_last,
    output logic       o_err_len,
    output logic       o_err_chk,
    output logic       o_err_tmo,
    output logic       o_drop,
    output logic       o_busy
);
    // One byte time is ten bit periods (start + 8 data + stop).
    localparam int unsigned       TMO_CYCLES = TIMEOUT_BYTES * 10 * (CLOCK_FREQ / BAUD_RATE);
    localparam int unsigned       TMO_W      = $clog2(TMO_CYCLES + 1);
    localparam int unsigned       IDX_W      = $clog2(MAX_LEN + 1);
    localparam int unsigned       ADDR_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0]        MAX_LEN_B  = 8'(MAX_LEN);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TMO_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHK     = 3'd3,
        S_OUT     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [7:0]       chk_q, chk_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_len_q, err_len_d;
    logic             err_chk_q, err_chk_d;
    logic             err_tmo_q, err_tmo_d;
    logic             drop_q, drop_d;
    logic             buf_we;
    logic [IDX_W-1:0] last_idx;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]       buf_q [MAX_LEN];

    assign last_idx = len_q - IDX_W'(1);
    assign buf_addr = idx_q[ADDR_W-1:0];

    // Payload storage has no reset; it is only observable while o_pkt_valid is high.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_q[buf_addr] <= i_rx_data;
        end
    end

    // Next-state, counters and pulse decisions.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        chk_d     = chk_q;
        tmo_d     = tmo_q;
        err_len_d = 1'b0;
        err_chk_d = 1'b0;
        err_tmo_d = 1'b0;
        drop_d    = 1'b0;
        buf_we    = 1'b0;

        // Timeout only matters mid-frame; a byte arriving on the expiry cycle wins.
        if (state_q inside {S_LEN, S_PAYLOAD, S_CHK}) begin
            if (i_rx_valid) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                err_tmo_d = 1'b1;
                tmo_d     = '0;
                state_d   = S_IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (i_rx_valid && (i_rx_data == SOF)) begin
                    tmo_d   = '0;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (i_rx_valid) begin
                    if ((i_rx_data == 8'h00) || (i_rx_data > MAX_LEN_B)) begin
                        err_len_d = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        len_d   = IDX_W'(i_rx_data);
                        chk_d   = i_rx_data;
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_rx_valid) begin
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ i_rx_data;
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = S_CHK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_CHK: begin
                if (i_rx_valid) begin
                    idx_d = '0;
                    if (i_rx_data == chk_q) begin
                        state_d = S_OUT;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                drop_d = i_rx_valid;
                if (i_pkt_ready) begin
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            chk_q     <= '0;
            tmo_q     <= '0;
            err_len_q <= 1'b0;
            err_chk_q <= 1'b0;
            err_tmo_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            chk_q     <= chk_d;
            tmo_q     <= tmo_d;
            err_len_q <= err_len_d;
            err_chk_q <= err_chk_d;
            err_tmo_q <= err_tmo_d;
            drop_q    <= drop_d;
        end
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_pkt_valid = (state_q == S_OUT);
    assign o_pkt_last  = o_pkt_valid && (idx_q == last_idx);
    assign o_pkt_data  = o_pkt_valid ? buf_q[buf_addr] : 8'h00;
    assign o_err_len   = err_len_q;
    assign o_err_chk   = err_chk_q;
    assign o_err_tmo   = err_tmo_q;
    assign o_drop      = drop_q;

endmodule
